// File: rtl/data_mem_responder_if.sv
// Load/store memory bus between the memory-access stage (master) and the
// data memory responder (slave).
//   req_*  : request channel, valid/ready handshake, byte address + store data
//   rsp_*  : response channel, valid/ready handshake, load data + error flag
interface data_mem_responder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_isLd;
  logic                  req_isSt;
  logic [31:0]           req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_isLd, req_isSt, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_isLd, req_isSt, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder: accepts one load/store at a time, services it
// against a word-organised RAM after LATENCY edges, and returns read data
// plus an error flag. Illegal requests (bad opcode, misaligned, out of
// range) never touch the RAM and bump a saturating error counter.
// Ports:
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset (RAM contents survive)
//   bus       : slave side of the request/response handshake bus
//   err_count : saturating count of error responses
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus,
  output logic [7:0]           err_count
);
  localparam int          DEPTH       = 2 ** ADDR_WIDTH;
  localparam logic [63:0] RANGE_LIMIT = 64'd4 << ADDR_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  typedef struct packed {
    logic                  is_ld;
    logic                  err;
    logic [ADDR_WIDTH-1:0] idx;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [1:0]            state;
  logic [3:0]            cnt;
  req_t                  pend_q;
  req_t                  new_req;
  req_t                  op;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  accept;
  logic                  enter_resp;

  // Decode the incoming request; the legality check is done once here and
  // carried along with the latched operands.
  always_comb begin
    new_req.is_ld = bus.req_isLd;
    new_req.err   = (bus.req_isLd == bus.req_isSt) ||
                    (bus.req_addr[1:0] != 2'b00) ||
                    ({32'd0, bus.req_addr} >= RANGE_LIMIT);
    new_req.idx   = bus.req_addr[ADDR_WIDTH+1:2];
    new_req.wdata = bus.req_wdata;
  end

  // With zero latency the RAM is accessed on the acceptance edge itself, so
  // the operands come straight from the bus; otherwise from the latch.
  assign op = (state == S_IDLE) ? new_req : pend_q;

  assign accept     = bus.req_valid && (state == S_IDLE);
  assign enter_resp = (accept && (LATENCY == 0)) ||
                      ((state == S_WAIT) && (cnt == 4'd1));

  assign bus.req_ready = (state == S_IDLE);
  assign bus.rsp_valid = (state == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      pend_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      err_count <= 8'd0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          pend_q <= new_req;
          if (LATENCY == 0) begin
            state <= S_RESP;
          end else begin
            state <= S_WAIT;
            cnt   <= 4'(LATENCY);
          end
        end
        S_WAIT: begin
          if (cnt == 4'd1) state <= S_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        S_RESP: if (bus.rsp_ready) begin
          state <= S_IDLE;
          err_q <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase

      if (enter_resp) begin
        err_q   <= op.err;
        rdata_q <= (op.is_ld && !op.err) ? mem[op.idx] : '0;
        if (op.err && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
      end
    end
  end

  // Store commits on the edge entering RESP; gated by reset so an aborted
  // or reset-time request can never reach the array. A legal non-load is
  // necessarily a store.
  always_ff @(posedge clk) begin
    if (reset && enter_resp && !op.is_ld && !op.err) mem[op.idx] <= op.wdata;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sel = 1'b0;          // 0: LATENCY=2 DUT, 1: LATENCY=0 DUT
  logic        req_valid = 1'b0;
  logic        is_ld = 1'b0;
  logic        is_st = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        rsp_ready = 1'b1;
  logic [7:0]  ec2, ec0;
  logic        o_req_ready, o_rsp_valid, o_err;
  logic [31:0] o_rdata;
  logic [7:0]  o_ec;
  int          passed = 0;
  int          total = 0;

  always #5 clk = ~clk;

  data_mem_responder_if #(.DATA_WIDTH(32)) if2 ();
  data_mem_responder_if #(.DATA_WIDTH(32)) if0 ();

  assign if2.req_valid = req_valid & ~sel;
  assign if0.req_valid = req_valid & sel;
  assign if2.req_isLd  = is_ld;
  assign if0.req_isLd  = is_ld;
  assign if2.req_isSt  = is_st;
  assign if0.req_isSt  = is_st;
  assign if2.req_addr  = addr;
  assign if0.req_addr  = addr;
  assign if2.req_wdata = wdata;
  assign if0.req_wdata = wdata;
  assign if2.rsp_ready = rsp_ready;
  assign if0.rsp_ready = rsp_ready;

  assign o_req_ready = sel ? if0.req_ready : if2.req_ready;
  assign o_rsp_valid = sel ? if0.rsp_valid : if2.rsp_valid;
  assign o_rdata     = sel ? if0.rsp_rdata : if2.rsp_rdata;
  assign o_err       = sel ? if0.rsp_err   : if2.rsp_err;
  assign o_ec        = sel ? ec0 : ec2;

  data_mem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .bus(if2), .err_count(ec2));
  data_mem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .LATENCY(0)) u_l0 (
    .clk(clk), .reset(reset), .bus(if0), .err_count(ec0));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One request from IDLE; hold = cycles of rsp_ready=0 once the response is up.
  task automatic do_req(input logic ld, input logic st, input logic [31:0] a,
                        input logic [31:0] d, input int lat, input int hold,
                        output logic [31:0] rd, output logic er);
    int cyc;
    rsp_ready = (hold == 0);
    req_valid = 1'b1; is_ld = ld; is_st = st; addr = a; wdata = d;
    tick();
    // Garbage on the idle request lines must not disturb the transaction.
    req_valid = 1'b0; is_ld = 1'($urandom); is_st = 1'($urandom);
    addr = $urandom; wdata = $urandom;
    chk("acc_rdy", 32'(o_req_ready), 32'd0);
    cyc = 0;
    while (!o_rsp_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(lat));
    rd = o_rdata;
    er = o_err;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_vld", 32'(o_rsp_valid), 32'd1);
      chk("hold_rd", o_rdata, rd);
      chk("hold_rdy", 32'(o_req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("rel_vld", 32'(o_rsp_valid), 32'd0);
    chk("rel_rdy", 32'(o_req_ready), 32'd1);
    chk("rel_err", 32'(o_err), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;

    // Reset state
    tick(); tick();
    chk("rst_rdy", 32'(o_req_ready), 32'd1);
    chk("rst_vld", 32'(o_rsp_valid), 32'd0);
    chk("rst_rd", o_rdata, 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_ec", 32'(o_ec), 32'd0);
    reset = 1'b1;
    tick();

    // LATENCY=2: store then load
    sel = 1'b0;
    do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2, 0, rd, er);
    chk("st_rd", rd, 32'd0);
    chk("st_err", 32'(er), 32'd0);
    do_req(1'b0, 1'b1, 32'h0, 32'h0BAD0000, 2, 0, rd, er);
    chk("st0_err", 32'(er), 32'd0);
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 2, 0, rd, er);
    chk("ld_rd", rd, 32'hDEADBEEF);
    chk("ld_err", 32'(er), 32'd0);

    // Backpressure
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 2, 5, rd, er);
    chk("bp_rd", rd, 32'hDEADBEEF);

    // Last legal word
    do_req(1'b0, 1'b1, 32'hFFC, 32'hCAFEF00D, 2, 0, rd, er);
    chk("top_st_err", 32'(er), 32'd0);
    do_req(1'b1, 1'b0, 32'hFFC, 32'h0, 2, 0, rd, er);
    chk("top_ld_rd", rd, 32'hCAFEF00D);

    // Errors
    do_req(1'b1, 1'b0, 32'h13, 32'h0, 2, 0, rd, er);
    chk("mis_err", 32'(er), 32'd1);
    chk("mis_rd", rd, 32'd0);
    do_req(1'b0, 1'b1, 32'h1000, 32'h12345678, 2, 0, rd, er);
    chk("oor_err", 32'(er), 32'd1);
    chk("oor_rd", rd, 32'd0);
    do_req(1'b1, 1'b1, 32'h10, 32'h55555555, 2, 0, rd, er);
    chk("both_err", 32'(er), 32'd1);
    chk("both_rd", rd, 32'd0);
    chk("ec3", 32'(o_ec), 32'd3);
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 2, 0, rd, er);
    chk("unch10", rd, 32'hDEADBEEF);
    do_req(1'b1, 1'b0, 32'h0, 32'h0, 2, 0, rd, er);
    chk("unch0", rd, 32'h0BAD0000);

    // LATENCY=0
    sel = 1'b1;
    do_req(1'b0, 1'b1, 32'h4, 32'h5, 0, 0, rd, er);
    chk("l0_st_err", 32'(er), 32'd0);
    do_req(1'b1, 1'b0, 32'h4, 32'h0, 0, 0, rd, er);
    chk("l0_ld_rd", rd, 32'h5);

    // Reset in WAIT aborts a pending store
    sel = 1'b0;
    do_req(1'b0, 1'b1, 32'h8, 32'h11, 2, 0, rd, er);
    do_req(1'b1, 1'b0, 32'h8, 32'h0, 2, 0, rd, er);
    chk("pre_rd", rd, 32'h11);
    req_valid = 1'b1; is_ld = 1'b0; is_st = 1'b1; addr = 32'h8; wdata = 32'hAA;
    tick();
    req_valid = 1'b0;
    tick();
    chk("mid_vld", 32'(o_rsp_valid), 32'd0);
    chk("mid_rdy", 32'(o_req_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("arst_rdy", 32'(o_req_ready), 32'd1);
    chk("arst_vld", 32'(o_rsp_valid), 32'd0);
    chk("arst_rd", o_rdata, 32'd0);
    chk("arst_ec", 32'(o_ec), 32'd0);
    tick(); tick();
    reset = 1'b1;
    tick();
    do_req(1'b1, 1'b0, 32'h8, 32'h0, 2, 0, rd, er);
    chk("abort_rd", rd, 32'h11);

    // Saturating error counter on the LATENCY=0 instance
    sel = 1'b1;
    for (int i = 0; i < 260; i++) begin
      do_req(1'b0, 1'b0, 32'h20, 32'h0, 0, 0, rd, er);
      chk("sat_ec", 32'(o_ec), (i < 255) ? 32'(i + 1) : 32'd255);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder side of the processor's load/store memory interface.
- Accepts one load or store request at a time from the memory-access stage over a valid/ready handshake.
- Services each request against an internal word-organised data RAM after a programmable latency, then returns read data and error status over a second valid/ready handshake.
- Replaces the zero-latency ideal data memory so the core can be exercised against realistic memory timing.

Parameters:
- ADDR_WIDTH, 10, word-index width; DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, data word width.
- LATENCY, 2, edges from request acceptance to response valid (0..15 legal).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_isLd  input  1  request is a load.
- req_isSt  input  1  request is a store.
- req_addr  input  32  byte address.
- req_wdata  input  DATA_WIDTH  store data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  DATA_WIDTH  load data; 0 for stores and errors.
- rsp_err  output  1  request was illegal.
- err_count  output  8  saturating count of error responses.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, err_count=0, latency counter=0.
  - RAM contents are not cleared.
  - Reset during WAIT aborts the request; a pending store is never written.
- FSM states: IDLE, WAIT, RESP.
  - req_ready=1 only in IDLE.
- Acceptance: req_valid && req_ready at a rising edge. At that edge, latch opcode, address and wdata, then compute err. err=1 if any of:
  - req_isLd == req_isSt (both or neither set);
  - req_addr[1:0] != 0 (misaligned);
  - req_addr >= 4*DEPTH (out of range).
- Next state after acceptance:
  - LATENCY=0: go to RESP.
  - LATENCY>0: go to WAIT with cnt=LATENCY.
- WAIT: each edge, if cnt==1 go to RESP, else decrement cnt. req_* inputs are ignored while in WAIT.
- Response timing: rsp_valid rises after edge E0+LATENCY, where E0 is the acceptance edge.
- Edge entering RESP:
  - Legal store: RAM[req_addr[ADDR_WIDTH+1:2]] <= wdata; rsp_rdata=0.
  - Legal load: rsp_rdata <= RAM[index], giving post-write-ordering data (every earlier store is complete).
  - Error: no RAM access; rsp_rdata=0; rsp_err=1; err_count increments, saturating at 255.
- RESP: rsp_valid=1. rsp_rdata and rsp_err stay stable until rsp_ready=1 at an edge.
  - At that edge: go to IDLE, rsp_valid=0, rsp_err=0. req_ready=1 in the following cycle (no same-cycle re-accept).
- Back-to-back throughput: one request per LATENCY+2 cycles when rsp_ready is held at 1.
- Width rules:
  - Address bits above ADDR_WIDTH+1 are used only for the range check.
  - DATA_WIDTH stores are full-word only; no byte enables.
- Inputs may change freely while req_ready=0.

Test Plan:
- Store then load, LATENCY=2:
  - Store addr 0x10, data 0xDEADBEEF, accepted at edge 1 -> rsp_valid rises after edge 3, rsp_err=0, rsp_rdata=0.
  - Load addr 0x10 -> rsp_rdata=0xDEADBEEF.
- Backpressure: hold rsp_ready=0 for 5 cycles after load of 0x10 -> rsp_valid stays 1, rdata stays 0xDEADBEEF, req_ready stays 0; release -> IDLE next cycle.
- Errors, each giving rsp_err=1, rsp_rdata=0, RAM unchanged:
  - load addr 0x13 (misaligned);
  - store addr 0x1000 with ADDR_WIDTH=10 (out of range);
  - req_isLd=req_isSt=1.
  - err_count=3 after the three.
- LATENCY=0: store addr 0x4 data 0x5 at edge E0 -> rsp_valid after E0; following load of 0x4 returns 0x5; req_ready low exactly 1 cycle per request with rsp_ready=1.
- Reset mid-operation: store addr 0x8 data 0xAA into a word holding 0x11, assert reset in WAIT -> outputs at reset values immediately; later load of 0x8 returns 0x11.
- Saturation: issue 260 illegal requests -> err_count=255 and holds.
